// File: rtl/smj_hand_ctrl.sv
// Serial front-end for the mahjong hand classifier: accepts five tiles one per
// handshake, keeps them insertion-sorted, classifies in an EVAL cycle, and pulses the result.
module smj_hand_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [5:0] tile,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out_data
);
    localparam int N_TILES = 5;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_EVAL    = 2'd1,
        ST_OUT     = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] count_q, count_d;
    logic       bad_q, bad_d;
    logic [5:0] s_q [N_TILES];
    logic [5:0] s_d [N_TILES];
    logic [5:0] ins_s [N_TILES];
    logic [2:0] pos_s;
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;
    logic [1:0] out_data_q, out_data_d;
    logic [1:0] class_s;
    logic       accept_s;

    function automatic logic tile_invalid(input logic [5:0] t);
        return (t[3:0] > 4'd8) || ((t[5:4] == 2'b00) && (t[3:0] > 4'd6));
    endfunction

    function automatic logic is_trip(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        return (a == b) && (b == c);
    endfunction

    // Runs stay within one suit only because 6-bit a+1 must match b exactly.
    function automatic logic is_seq(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
        return (a[5:4] != 2'b00) && (6'(a + 6'd1) == b) && (6'(b + 6'd1) == c);
    endfunction

    assign accept_s  = in_valid && in_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Insertion slot for the incoming tile and the shifted array it produces.
    always_comb begin
        pos_s = 3'd0;
        for (int i = 0; i < N_TILES; i++) begin
            if ((3'(i) < count_q) && (s_q[i] <= tile)) begin
                pos_s = pos_s + 3'd1;
            end else begin
                pos_s = pos_s;
            end
        end
        for (int i = 0; i < N_TILES; i++) begin
            if (3'(i) < pos_s) begin
                ins_s[i] = s_q[i];
            end else if (3'(i) == pos_s) begin
                ins_s[i] = tile;
            end else begin
                ins_s[i] = s_q[(i == 0) ? 0 : i - 1];
            end
        end
    end

    // Hand classification on the sorted array.
    always_comb begin
        class_s = 2'b00;
        if (bad_q || ((s_q[0] == s_q[1]) && is_trip(s_q[1], s_q[2], s_q[3]) && (s_q[3] == s_q[4]))) begin
            class_s = 2'b01;
        end else if (((s_q[0] == s_q[1]) && is_trip(s_q[2], s_q[3], s_q[4])) ||
                     ((s_q[3] == s_q[4]) && is_trip(s_q[0], s_q[1], s_q[2]))) begin
            class_s = 2'b11;
        end else if (((s_q[0] == s_q[1]) && is_seq(s_q[2], s_q[3], s_q[4])) ||
                     ((s_q[3] == s_q[4]) && is_seq(s_q[0], s_q[1], s_q[2])) ||
                     ((s_q[2] == s_q[3]) && is_seq(s_q[0], s_q[1], s_q[4]))) begin
            class_s = 2'b10;
        end else begin
            class_s = 2'b00;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        bad_d       = bad_q;
        s_d         = s_q;
        out_valid_d = 1'b0;
        out_data_d  = 2'b00;
        case (state_q)
            ST_COLLECT: begin
                if (accept_s) begin
                    s_d     = ins_s;
                    count_d = count_q + 3'd1;
                    bad_d   = bad_q | tile_invalid(tile);
                    if (count_q == 3'(N_TILES - 1)) begin
                        state_d = ST_EVAL;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_EVAL: begin
                state_d     = ST_OUT;
                out_valid_d = 1'b1;
                out_data_d  = class_s;
            end
            ST_OUT: begin
                state_d = ST_COLLECT;
                count_d = 3'd0;
                bad_d   = 1'b0;
            end
            default: begin
                state_d = ST_COLLECT;
                count_d = 3'd0;
                bad_d   = 1'b0;
            end
        endcase
        in_ready_d = (state_d == ST_COLLECT);
    end

    // State, tile array and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COLLECT;
            count_q     <= 3'd0;
            bad_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 2'b00;
            for (int i = 0; i < N_TILES; i++) begin
                s_q[i] <= 6'd0;
            end
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            bad_q       <= bad_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < N_TILES; i++) begin
                s_q[i] <= s_d[i];
            end
        end
    end
endmodule

// File: tb/tb_smj_hand_ctrl.sv
// Directed bench for smj_hand_ctrl: table of hands with expected classes plus
// hand-written reset and ignored-input sequences.
module tb_smj_hand_ctrl;
    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [5:0] tile;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0][5:0] t;
        int              max_gap;
        logic [1:0]      exp;
        string           name;
    } vec_t;

    vec_t vecs[$];

    smj_hand_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .tile     (tile),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string n, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", n, got, exp);
        end
    endtask

    task automatic add_vec(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c,
                           input logic [5:0] d, input logic [5:0] e, input int g,
                           input logic [1:0] x, input string n);
        vec_t v;
        v.t[0] = a; v.t[1] = b; v.t[2] = c; v.t[3] = d; v.t[4] = e;
        v.max_gap = g;
        v.exp = x;
        v.name = n;
        vecs.push_back(v);
    endtask

    // Called at posedge+1; presents a tile and returns at posedge+1 after it is taken.
    task automatic accept(input logic [5:0] t, input string n);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        tile = t;
        for (int k = 0; k < 20; k++) begin
            if (!done) begin
                if (in_ready) done = 1'b1;
                else done = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s_accept_timeout got=in_ready_low expected=in_ready_high", n);
        end
    endtask

    task automatic run_hand(input logic [4:0][5:0] t, input int max_gap, input logic [1:0] exp,
                            input string n, input bit hold);
        int gap;
        for (int i = 0; i < 5; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (gap) begin
                in_valid = 1'b0;
                tile = 6'h3f;
                @(posedge clk);
                #1;
            end
            accept(t[i], n);
        end
        in_valid = hold;
        tile = 6'h07;
        check({n, "_eval_ready"}, 8'(in_ready), 8'h0);
        check({n, "_eval_valid"}, 8'(out_valid), 8'h0);
        @(posedge clk);
        #1;
        tile = 6'h19;
        check({n, "_out_valid"}, 8'(out_valid), 8'h1);
        check({n, "_out_data"}, 8'(out_data), 8'(exp));
        check({n, "_out_ready"}, 8'(in_ready), 8'h0);
        @(posedge clk);
        #1;
        check({n, "_post_valid"}, 8'(out_valid), 8'h0);
        check({n, "_post_data"}, 8'(out_data), 8'h0);
        check({n, "_post_ready"}, 8'(in_ready), 8'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [4:0][5:0] h;
        rst_n = 1'b0;
        in_valid = 1'b0;
        tile = 6'h00;

        add_vec(6'h13, 6'h11, 6'h14, 6'h11, 6'h12, 0, 2'b10, "pair_seq");
        add_vec(6'h22, 6'h05, 6'h05, 6'h22, 6'h05, 3, 2'b11, "pair_trip_gaps");
        add_vec(6'h07, 6'h00, 6'h00, 6'h01, 6'h02, 0, 2'b01, "honor_rank7");
        add_vec(6'h19, 6'h11, 6'h11, 6'h12, 6'h13, 1, 2'b01, "rank9");
        add_vec(6'h33, 6'h33, 6'h33, 6'h33, 6'h33, 0, 2'b01, "five_same");
        add_vec(6'h00, 6'h01, 6'h02, 6'h03, 6'h03, 0, 2'b00, "honor_run");
        add_vec(6'h18, 6'h20, 6'h21, 6'h05, 6'h05, 2, 2'b00, "cross_suit");
        add_vec(6'h12, 6'h13, 6'h12, 6'h11, 6'h12, 0, 2'b10, "mid_pair_seq");
        add_vec(6'h06, 6'h38, 6'h06, 6'h38, 6'h06, 0, 2'b11, "rank_bounds");

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 8'(in_ready), 8'h1);
        check("reset_valid", 8'(out_valid), 8'h0);
        check("reset_data", 8'(out_data), 8'h0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            run_hand(vecs[k].t, vecs[k].max_gap, vecs[k].exp, vecs[k].name, 1'b0);
        end

        // in_valid stays high through EVAL/OUT with invalid tiles on the bus.
        h[0] = 6'h11; h[1] = 6'h11; h[2] = 6'h12; h[3] = 6'h13; h[4] = 6'h14;
        run_hand(h, 0, 2'b10, "hold_first", 1'b1);
        h[0] = 6'h21; h[1] = 6'h22; h[2] = 6'h23; h[3] = 6'h25; h[4] = 6'h25;
        run_hand(h, 0, 2'b10, "hold_next", 1'b0);

        // Reset while the result is on the outputs.
        h[0] = 6'h31; h[1] = 6'h31; h[2] = 6'h31; h[3] = 6'h36; h[4] = 6'h36;
        for (int i = 0; i < 5; i++) accept(h[i], "rst_out");
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_out_pre_valid", 8'(out_valid), 8'h1);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 8'(out_valid), 8'h0);
        check("rst_out_data", 8'(out_data), 8'h0);
        check("rst_out_ready", 8'(in_ready), 8'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset mid-hand discards the partial hand.
        accept(6'h07, "rst_mid");
        accept(6'h33, "rst_mid");
        accept(6'h31, "rst_mid");
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 8'(in_ready), 8'h1);
        check("rst_mid_valid", 8'(out_valid), 8'h0);
        check("rst_mid_data", 8'(out_data), 8'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_hand(h, 0, 2'b11, "after_reset", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
